// File: rtl/fp_exu_seq.sv
// Sequential FP execute stage: dispatches ops to a simple-op unit, a long-op unit or a move path,
// and retires results in order through an output FIFO with sticky exception flags.
module fp_exu_seq #(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 4,
  parameter int OBUF_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              fp_exu_i_clk,
  input  logic              fp_exu_i_rst_n,
  input  logic              fp_exu_i_valid,
  output logic              fp_exu_o_ready,
  input  logic [3:0]        fp_exu_i_op,
  input  logic [63:0]       fp_exu_i_data1,
  input  logic [63:0]       fp_exu_i_data2,
  input  logic [63:0]       fp_exu_i_data3,
  input  logic [1:0]        fp_exu_i_fmt,
  input  logic [2:0]        fp_exu_i_rm,
  input  logic [TAG_W-1:0]  fp_exu_i_tag,
  output logic [3:0]        fp_exu_o_sop_op,
  output logic [63:0]       fp_exu_o_sop_data1,
  output logic [63:0]       fp_exu_o_sop_data2,
  output logic [1:0]        fp_exu_o_sop_fmt,
  output logic [2:0]        fp_exu_o_sop_rm,
  input  logic [63:0]       fp_exu_i_sop_result,
  input  logic [4:0]        fp_exu_i_sop_flags,
  output logic              fp_exu_o_lop_valid,
  input  logic              fp_exu_i_lop_ready,
  output logic [3:0]        fp_exu_o_lop_op,
  output logic [63:0]       fp_exu_o_lop_data1,
  output logic [63:0]       fp_exu_o_lop_data2,
  output logic [63:0]       fp_exu_o_lop_data3,
  output logic [1:0]        fp_exu_o_lop_fmt,
  output logic [2:0]        fp_exu_o_lop_rm,
  input  logic              fp_exu_i_lop_resp_valid,
  input  logic [63:0]       fp_exu_i_lop_result,
  input  logic [4:0]        fp_exu_i_lop_flags,
  output logic              fp_exu_o_valid,
  input  logic              fp_exu_i_ready,
  output logic [XLEN-1:0]   fp_exu_o_result,
  output logic [4:0]        fp_exu_o_flags,
  output logic [TAG_W-1:0]  fp_exu_o_tag,
  output logic              fp_exu_o_err,
  input  logic              fp_exu_i_fflags_clr,
  output logic [4:0]        fp_exu_o_fflags,
  output logic              fp_exu_o_busy
);

  localparam int PW = $clog2(OBUF_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(OBUF_DEPTH);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  localparam logic [4:0] FLAG_NV = 5'b10000;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e             state_q;
  logic               lop_valid_q;
  logic [3:0]         lop_op_q;
  logic [63:0]        lop_data1_q, lop_data2_q, lop_data3_q;
  logic [1:0]         lop_fmt_q;
  logic [2:0]         lop_rm_q;
  logic [TAG_W-1:0]   tag_q;
  logic [7:0]         wd_q;

  logic [XLEN-1:0]    mem_res_q [OBUF_DEPTH];
  logic [4:0]         mem_fl_q  [OBUF_DEPTH];
  logic [TAG_W-1:0]   mem_tag_q [OBUF_DEPTH];
  logic               mem_err_q [OBUF_DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PW:0]        cnt_q;
  logic [4:0]         fflags_q, fflags_d;

  logic is_long, is_move, is_ill, accept, pop, wait_done;
  logic               push;
  logic [XLEN-1:0]    push_res;
  logic [4:0]         push_fl;
  logic [TAG_W-1:0]   push_tag;
  logic               push_err;

  // Handshakes: a transfer happens on a rising clock edge where both valid and ready are high;
  // valid never waits for ready, and ready never depends on valid.
  assign fp_exu_o_ready = (state_q == S_IDLE) && (cnt_q < DEPTH_C);
  assign accept  = fp_exu_i_valid && fp_exu_o_ready;
  assign pop     = fp_exu_o_valid && fp_exu_i_ready;

  assign is_long = (fp_exu_i_op <= 4'd6) || (fp_exu_i_op == 4'd13);
  assign is_move = (fp_exu_i_op == 4'd11) || (fp_exu_i_op == 4'd12);
  assign is_ill  = (fp_exu_i_op == 4'd15);

  assign fp_exu_o_sop_op    = fp_exu_i_op;
  assign fp_exu_o_sop_data1 = fp_exu_i_data1;
  assign fp_exu_o_sop_data2 = fp_exu_i_data2;
  assign fp_exu_o_sop_fmt   = fp_exu_i_fmt;
  assign fp_exu_o_sop_rm    = fp_exu_i_rm;

  assign fp_exu_o_lop_valid = lop_valid_q;
  assign fp_exu_o_lop_op    = lop_op_q;
  assign fp_exu_o_lop_data1 = lop_data1_q;
  assign fp_exu_o_lop_data2 = lop_data2_q;
  assign fp_exu_o_lop_data3 = lop_data3_q;
  assign fp_exu_o_lop_fmt   = lop_fmt_q;
  assign fp_exu_o_lop_rm    = lop_rm_q;

  // Pushes come either from an IDLE accept or from WAIT completion, never both in one cycle.
  always_comb begin
    push      = 1'b0;
    push_res  = '0;
    push_fl   = '0;
    push_tag  = fp_exu_i_tag;
    push_err  = 1'b0;
    wait_done = 1'b0;
    if (accept && !is_long) begin
      push = 1'b1;
      if (is_move) begin
        push_res = fp_exu_i_data1[XLEN-1:0];
      end else if (is_ill) begin
        push_fl  = FLAG_NV;
        push_err = 1'b1;
      end else begin
        push_res = fp_exu_i_sop_result[XLEN-1:0];
        push_fl  = fp_exu_i_sop_flags;
      end
    end else if (state_q == S_WAIT) begin
      push_tag = tag_q;
      if (fp_exu_i_lop_resp_valid) begin
        push      = 1'b1;
        wait_done = 1'b1;
        push_res  = fp_exu_i_lop_result[XLEN-1:0];
        push_fl   = fp_exu_i_lop_flags;
      end else if (wd_q == WD_LAST) begin
        push      = 1'b1;
        wait_done = 1'b1;
        push_fl   = FLAG_NV;
        push_err  = 1'b1;
      end
    end
  end

  always_ff @(posedge fp_exu_i_clk) begin
    if (!fp_exu_i_rst_n) begin
      state_q     <= S_IDLE;
      lop_valid_q <= 1'b0;
      lop_op_q    <= '0;
      lop_data1_q <= '0;
      lop_data2_q <= '0;
      lop_data3_q <= '0;
      lop_fmt_q   <= '0;
      lop_rm_q    <= '0;
      tag_q       <= '0;
      wd_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept && is_long) begin
          lop_op_q    <= fp_exu_i_op;
          lop_data1_q <= fp_exu_i_data1;
          lop_data2_q <= fp_exu_i_data2;
          lop_data3_q <= fp_exu_i_data3;
          lop_fmt_q   <= fp_exu_i_fmt;
          lop_rm_q    <= fp_exu_i_rm;
          tag_q       <= fp_exu_i_tag;
          lop_valid_q <= 1'b1;
          state_q     <= S_REQ;
        end
        S_REQ: if (fp_exu_i_lop_ready) begin
          lop_valid_q <= 1'b0;
          wd_q        <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          wd_q <= wd_q + 8'd1;
          if (wait_done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge fp_exu_i_clk) begin
    if (push) begin
      mem_res_q[wr_ptr_q] <= push_res;
      mem_fl_q[wr_ptr_q]  <= push_fl;
      mem_tag_q[wr_ptr_q] <= push_tag;
      mem_err_q[wr_ptr_q] <= push_err;
    end
  end

  // A clear coinciding with a pop keeps only the flags retiring in that cycle.
  always_comb begin
    fflags_d = fp_exu_i_fflags_clr ? 5'b0 : fflags_q;
    if (pop) fflags_d = fflags_d | fp_exu_o_flags;
  end

  always_ff @(posedge fp_exu_i_clk) begin
    if (!fp_exu_i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      fflags_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      fflags_q <= fflags_d;
    end
  end

  assign fp_exu_o_valid  = (cnt_q != '0);
  assign fp_exu_o_result = mem_res_q[rd_ptr_q];
  assign fp_exu_o_flags  = mem_fl_q[rd_ptr_q];
  assign fp_exu_o_tag    = mem_tag_q[rd_ptr_q];
  assign fp_exu_o_err    = mem_err_q[rd_ptr_q];
  assign fp_exu_o_fflags = fflags_q;
  assign fp_exu_o_busy   = (state_q != S_IDLE) || (cnt_q != '0);

endmodule

// File: tb/tb_fp_exu_seq.sv
// Directed bench for fp_exu_seq: dispatch paths, long-op handshake, FIFO backpressure,
// watchdog retire, illegal op, sticky flag clear and mid-operation reset.
module tb_fp_exu_seq;

  localparam int XLEN = 32;
  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid, o_ready;
  logic [3:0]        op;
  logic [63:0]       data1, data2, data3;
  logic [1:0]        fmt;
  logic [2:0]        rm;
  logic [TAG_W-1:0]  tag;
  logic [3:0]        sop_op;
  logic [63:0]       sop_data1, sop_data2;
  logic [1:0]        sop_fmt;
  logic [2:0]        sop_rm;
  logic [63:0]       sop_result;
  logic [4:0]        sop_flags;
  logic              lop_valid, lop_ready;
  logic [3:0]        lop_op;
  logic [63:0]       lop_data1, lop_data2, lop_data3;
  logic [1:0]        lop_fmt;
  logic [2:0]        lop_rm;
  logic              lop_resp_valid;
  logic [63:0]       lop_result;
  logic [4:0]        lop_flags;
  logic              o_valid, i_ready;
  logic [XLEN-1:0]   o_result;
  logic [4:0]        o_flags;
  logic [TAG_W-1:0]  o_tag;
  logic              o_err;
  logic              fflags_clr;
  logic [4:0]        fflags;
  logic              busy;

  int checks = 0;
  int failures = 0;

  fp_exu_seq #(.XLEN(XLEN), .TAG_W(TAG_W), .OBUF_DEPTH(4), .TIMEOUT(255)) dut (
    .fp_exu_i_clk(clk), .fp_exu_i_rst_n(rst_n),
    .fp_exu_i_valid(valid), .fp_exu_o_ready(o_ready),
    .fp_exu_i_op(op), .fp_exu_i_data1(data1), .fp_exu_i_data2(data2), .fp_exu_i_data3(data3),
    .fp_exu_i_fmt(fmt), .fp_exu_i_rm(rm), .fp_exu_i_tag(tag),
    .fp_exu_o_sop_op(sop_op), .fp_exu_o_sop_data1(sop_data1), .fp_exu_o_sop_data2(sop_data2),
    .fp_exu_o_sop_fmt(sop_fmt), .fp_exu_o_sop_rm(sop_rm),
    .fp_exu_i_sop_result(sop_result), .fp_exu_i_sop_flags(sop_flags),
    .fp_exu_o_lop_valid(lop_valid), .fp_exu_i_lop_ready(lop_ready),
    .fp_exu_o_lop_op(lop_op), .fp_exu_o_lop_data1(lop_data1), .fp_exu_o_lop_data2(lop_data2),
    .fp_exu_o_lop_data3(lop_data3), .fp_exu_o_lop_fmt(lop_fmt), .fp_exu_o_lop_rm(lop_rm),
    .fp_exu_i_lop_resp_valid(lop_resp_valid), .fp_exu_i_lop_result(lop_result),
    .fp_exu_i_lop_flags(lop_flags),
    .fp_exu_o_valid(o_valid), .fp_exu_i_ready(i_ready), .fp_exu_o_result(o_result),
    .fp_exu_o_flags(o_flags), .fp_exu_o_tag(o_tag), .fp_exu_o_err(o_err),
    .fp_exu_i_fflags_clr(fflags_clr), .fp_exu_o_fflags(fflags), .fp_exu_o_busy(busy)
  );

  // Clock and global time bound
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  // One clock edge, then settle; all driving and sampling happens 1ns after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic drive_op(input logic [3:0] o, input logic [TAG_W-1:0] t, input logic [63:0] d1);
    valid = 1'b1;
    op    = o;
    tag   = t;
    data1 = d1;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; op = '0; data1 = '0; data2 = '0; data3 = '0;
    fmt = '0; rm = '0; tag = '0; sop_result = '0; sop_flags = '0; lop_ready = 1'b0;
    lop_resp_valid = 1'b0; lop_result = '0; lop_flags = '0; i_ready = 1'b0; fflags_clr = 1'b0;
    #1;
    step(); step();
    check("rst_o_valid", o_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fflags", fflags, 0);
    check("rst_lop_valid", lop_valid, 0);
    check("rst_o_ready", o_ready, 1);
    rst_n = 1'b1;
    step();

    // Simple op: SGNJ, latency 1
    drive_op(4'd7, 4'd3, 64'h1234);
    sop_result = 64'h3F80_0000; sop_flags = 5'b0; i_ready = 1'b1;
    check("sop_copy_op", sop_op, 4'd7);
    step();
    valid = 1'b0;
    check("sgnj_valid", o_valid, 1);
    check("sgnj_result", o_result, 32'h3F80_0000);
    check("sgnj_tag", o_tag, 3);
    check("sgnj_err", o_err, 0);
    step();
    check("sgnj_popped", o_valid, 0);
    check("sgnj_fflags", fflags, 0);

    // Long op FADD with delayed lop_ready, CMP waits behind it
    i_ready = 1'b0;
    drive_op(4'd4, 4'd1, 64'hAAAA_0001);
    data2 = 64'hBBBB_0002; data3 = 64'hCCCC_0003; fmt = 2'd1; rm = 3'd3;
    step();
    drive_op(4'd8, 4'd2, 64'h5);
    data2 = 64'h6; data3 = 64'h7; fmt = 2'd0; rm = 3'd0;
    sop_result = 64'h1; sop_flags = 5'b0;
    check("req_lop_valid", lop_valid, 1);
    check("req_lop_op", lop_op, 4'd4);
    check("req_lop_data2", lop_data2, 64'hBBBB_0002);
    check("req_lop_rm", lop_rm, 3'd3);
    check("req_o_ready", o_ready, 0);
    check("req_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("req_hold_valid", lop_valid, 1);
      check("req_hold_data1", lop_data1, 64'hAAAA_0001);
      check("req_hold_data3", lop_data3, 64'hCCCC_0003);
      check("req_hold_ready", o_ready, 0);
    end
    lop_ready = 1'b1;
    step();
    lop_ready = 1'b0;
    check("wait_lop_valid", lop_valid, 0);
    check("wait_o_ready", o_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("wait_no_out", o_valid, 0);
      check("wait_ready_low", o_ready, 0);
    end
    lop_resp_valid = 1'b1; lop_result = 64'h4040_0000; lop_flags = 5'b00001;
    step();
    lop_resp_valid = 1'b0;
    check("fadd_valid", o_valid, 1);
    check("fadd_tag", o_tag, 1);
    check("fadd_result", o_result, 32'h4040_0000);
    check("fadd_flags", o_flags, 5'b00001);
    check("fadd_err", o_err, 0);
    check("post_resp_ready", o_ready, 1);
    step();
    valid = 1'b0;
    check("stall_head_tag", o_tag, 1);
    i_ready = 1'b1;
    step();
    check("cmp_valid", o_valid, 1);
    check("cmp_tag", o_tag, 2);
    check("cmp_result", o_result, 32'h1);
    step();
    check("order_empty", o_valid, 0);
    check("fadd_fflags", fflags, 5'b00001);

    // FIFO full backpressure with MV_I2F
    fflags_clr = 1'b1; i_ready = 1'b0;
    step();
    fflags_clr = 1'b0;
    check("clr_fflags", fflags, 0);
    for (int i = 0; i < 4; i++) begin
      drive_op(4'd11, 4'(8 + i), 64'hFFFF_0000_0000_00A0 + 64'(i));
      check("fill_ready", o_ready, 1);
      step();
    end
    drive_op(4'd11, 4'd12, 64'h0000_0000_0000_00A4);
    check("full_ready", o_ready, 0);
    step();
    check("full_still_low", o_ready, 0);
    check("full_head", o_result, 32'hA0);
    check("mv_flags", o_flags, 0);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check("after_pop_ready", o_ready, 1);
    check("after_pop_head", o_result, 32'hA1);
    step();
    valid = 1'b0;
    check("refull_ready", o_ready, 0);
    i_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("drain_valid", o_valid, 1);
      check("drain_result", o_result, 64'hA0 + 64'(i));
      check("drain_tag", o_tag, 64'(8 + i));
      step();
    end
    check("drain_empty", o_valid, 0);
    check("mv_fflags", fflags, 0);
    i_ready = 1'b0;

    // Watchdog on FMUL
    lop_ready = 1'b1;
    drive_op(4'd6, 4'd5, 64'h77);
    step();
    valid = 1'b0;
    step();
    lop_ready = 1'b0;
    check("wd_wait_entered", lop_valid, 0);
    repeat (254) step();
    check("wd_not_yet", o_valid, 0);
    check("wd_busy", busy, 1);
    step();
    check("wd_valid", o_valid, 1);
    check("wd_result", o_result, 0);
    check("wd_flags", o_flags, 5'b10000);
    check("wd_err", o_err, 1);
    check("wd_tag", o_tag, 5);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check("wd_fflags", fflags, 5'b10000);
    lop_resp_valid = 1'b1; lop_result = 64'h99; lop_flags = 5'b00010;
    step();
    lop_resp_valid = 1'b0;
    step();
    check("stray_no_out", o_valid, 0);
    check("stray_idle", busy, 0);

    // Illegal op, then clear coinciding with pop
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    drive_op(4'd15, 4'd6, 64'h1234_5678);
    step();
    valid = 1'b0;
    check("ill_valid", o_valid, 1);
    check("ill_result", o_result, 0);
    check("ill_flags", o_flags, 5'b10000);
    check("ill_err", o_err, 1);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check("ill_fflags", fflags, 5'b10000);
    drive_op(4'd7, 4'd7, 64'h0);
    sop_result = 64'h55; sop_flags = 5'b00100;
    step();
    valid = 1'b0;
    check("dz_flags", o_flags, 5'b00100);
    i_ready = 1'b1; fflags_clr = 1'b1;
    step();
    i_ready = 1'b0; fflags_clr = 1'b0;
    check("clr_pop_fflags", fflags, 5'b00100);
    check("clr_pop_empty", o_valid, 0);

    // Reset during WAIT
    lop_ready = 1'b1;
    drive_op(4'd4, 4'd9, 64'h1);
    step();
    valid = 1'b0;
    step();
    lop_ready = 1'b0;
    step(); step();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_lop_valid", lop_valid, 0);
    check("mid_rst_fflags", fflags, 0);
    check("mid_rst_ready", o_ready, 1);
    lop_resp_valid = 1'b1; lop_result = 64'h3; lop_flags = 5'b00001;
    step();
    lop_resp_valid = 1'b0;
    step();
    check("late_resp_no_out", o_valid, 0);
    check("late_resp_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
